// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin arbiter/sequencer sharing one exact WIDTH x WIDTH
// unsigned multiplier among NREQ requesters. Operands are registered on accept,
// the product is registered after the combinational multiplier, and results
// return on a single valid/ready channel tagged with the requester index.
// Optional build macro MUL_SHARE_ARB_PIPE_EN adds a PIPE state and a second
// product register (latency 3 instead of 2).

// Exact unsigned multiplier: AND-array partial products, carry-save
// reduction to two rows, then a grouped carry-lookahead final adder.
module mul_share_arb_mult #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod
);
  localparam int PW  = 2 * WIDTH;
  localparam int CW  = $clog2(PW);
  localparam int GRP = 4;

  logic [PW-1:0] pp    [WIDTH];
  logic [PW-1:0] red_s [WIDTH-1];
  logic [PW-1:0] red_c [WIDTH-1];
  logic [PW-1:0] gen;
  logic [PW-1:0] prop;
  logic [PW-1:0] sum_out;
  logic          grp_carry;
  logic          bit_carry;

  // Partial product row gi is A gated by B[gi], shifted to its weight.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pp
      assign pp[gi] = PW'({WIDTH{b[gi]}} & a) << gi;
    end
  endgenerate

  // Carry-save reduction: each stage folds one more row into (sum, carry).
  // The running value red_s + red_c never exceeds the final product, so the
  // carry shift cannot lose a set bit off the top.
  assign red_s[0] = pp[0];
  assign red_c[0] = pp[1];
  generate
    for (gi = 1; gi < WIDTH - 1; gi++) begin : g_csa
      assign red_s[gi] = red_s[gi-1] ^ red_c[gi-1] ^ pp[gi+1];
      assign red_c[gi] = ((red_s[gi-1] & red_c[gi-1]) |
                          (red_s[gi-1] & pp[gi+1])   |
                          (red_c[gi-1] & pp[gi+1])) << 1;
    end
  endgenerate

  assign gen  = red_s[WIDTH-2] & red_c[WIDTH-2];
  assign prop = red_s[WIDTH-2] ^ red_c[WIDTH-2];

  // Carry into bit lo+n given carry-in at bit lo, by full lookahead.
  function automatic logic la_carry(input logic [PW-1:0] g,
                                    input logic [PW-1:0] p,
                                    input int lo, input int n,
                                    input logic cin);
    logic c;
    logic t;
    c = cin;
    for (int m = 0; m < n; m++) c = c & p[CW'(lo + m)];
    for (int k = 0; k < n; k++) begin
      t = g[CW'(lo + k)];
      for (int m = k + 1; m < n; m++) t = t & p[CW'(lo + m)];
      c = c | t;
    end
    return c;
  endfunction

  // Final adder: 4-bit lookahead groups, group carries chained between groups.
  always_comb begin
    sum_out   = '0;
    grp_carry = 1'b0;
    bit_carry = 1'b0;
    for (int base = 0; base < PW; base += GRP) begin
      for (int j = 0; j < GRP; j++) begin
        if (base + j < PW) begin
          bit_carry = la_carry(gen, prop, base, j, grp_carry);
          sum_out[CW'(base + j)] = prop[CW'(base + j)] ^ bit_carry;
        end
      end
      grp_carry = la_carry(gen, prop, base,
                           (PW - base < GRP) ? (PW - base) : GRP, grp_carry);
    end
  end

  assign prod = sum_out;
endmodule

// Top level: arbitration FSM, operand/product registers, response channel.
module mul_share_arb #(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_prod,
  output logic                  busy
);
  localparam logic [IDW:0]   NREQ_W  = NREQ[IDW:0];
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

`ifdef MUL_SHARE_ARB_PIPE_EN
  typedef enum logic [1:0] {IDLE, CALC, PIPE, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
`endif

  state_t               state_reg, state_next;
  logic [IDW-1:0]       ptr_reg;
  logic [IDW-1:0]       ptr_next;
  logic [WIDTH-1:0]     op_a_reg, op_b_reg;
  logic [IDW-1:0]       id_reg;
  logic [2*WIDTH-1:0]   prod_reg;
`ifdef MUL_SHARE_ARB_PIPE_EN
  logic [2*WIDTH-1:0]   prod2_reg;
`endif
  logic [2*WIDTH-1:0]   mul_out;
  logic [IDW-1:0]       grant;
  logic                 found;
  logic                 grant_window;
  logic                 accept;
  logic [IDW:0]         cand_wide;
  logic [IDW-1:0]       cand;
  logic [WIDTH-1:0]     a_sel, b_sel;

  // Round-robin search starting at ptr; first valid requester wins.
  always_comb begin
    found     = 1'b0;
    grant     = '0;
    cand_wide = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_wide = {1'b0, ptr_reg} + k[IDW:0];
      if (cand_wide >= NREQ_W) cand_wide = cand_wide - NREQ_W;
      cand = cand_wide[IDW-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  // Grants are offered only when idle or when the current response retires.
  assign grant_window = !rst && ((state_reg == IDLE) ||
                                 (state_reg == RESP && rsp_ready));
  assign accept       = grant_window && found;
  assign ptr_next     = (grant == LAST_ID) ? '0 : grant + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      localparam logic [IDW-1:0] GI_ID = IDW'(gi);
      assign req_ready[gi] = accept && (grant == GI_ID);
    end
  endgenerate

  // Operand mux for the winning requester; only feeds the operand registers.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant == k[IDW-1:0]) begin
        a_sel = req_a[k*WIDTH +: WIDTH];
        b_sel = req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  mul_share_arb_mult #(.WIDTH(WIDTH)) u_mult (
    .a    (op_a_reg),
    .b    (op_b_reg),
    .prod (mul_out)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state_reg;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_next = CALC;
      end
`ifdef MUL_SHARE_ARB_PIPE_EN
      CALC: state_next = PIPE;
      PIPE: state_next = RESP;
`else
      CALC: state_next = RESP;
`endif
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = accept ? CALC : IDLE;
      end
      default: begin
        state_next = IDLE;
        busy       = 1'b0;
      end
    endcase
  end

  // Operand capture on accept, pointer advance, product registration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg   <= '0;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      id_reg    <= '0;
      prod_reg  <= '0;
`ifdef MUL_SHARE_ARB_PIPE_EN
      prod2_reg <= '0;
`endif
    end else begin
      if (accept) begin
        op_a_reg <= a_sel;
        op_b_reg <= b_sel;
        id_reg   <= grant;
        ptr_reg  <= ptr_next;
      end
      if (state_reg == CALC) prod_reg <= mul_out;
`ifdef MUL_SHARE_ARB_PIPE_EN
      if (state_reg == PIPE) prod2_reg <= prod_reg;
`endif
    end
  end

  assign rsp_id = id_reg;
`ifdef MUL_SHARE_ARB_PIPE_EN
  assign rsp_prod = prod2_reg;
`else
  assign rsp_prod = prod_reg;
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed and randomized checks for mul_share_arb (WIDTH=8, NREQ=4).
module tb_mul_share_arb;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
`ifdef MUL_SHARE_ARB_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [2*WIDTH-1:0]    rsp_prod;
  logic                  busy;

  int n_vec  = 0;
  int n_miss = 0;

  mul_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input int a, input int b);
    req_a[id*WIDTH +: WIDTH] = WIDTH'(a);
    req_b[id*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  // Wait (bounded) for rsp_valid; cyc counts cycles spent waiting.
  task automatic wait_rsp(output int cyc);
    cyc = 0;
    #1;
    while (!rsp_valid && cyc < 20) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    check_val("rsp_arrives", 32'(rsp_valid), 1);
  endtask

  task automatic run_single(input int id, input int a, input int b, input int want);
    int cyc;
    set_ops(id, a, b);
    req_valid = 4'(1 << id);
    rsp_ready = 1'b1;
    #1;
    check_val("single_grant", 32'(req_ready), 1 << id);
    next_cycle;
    req_valid = '0;
    wait_rsp(cyc);
    check_val("single_latency", cyc + 1, LAT);
    check_val("single_prod", 32'(rsp_prod), want);
    check_val("single_id", 32'(rsp_id), id);
    $display("txn single id=%0d a=%0d b=%0d prod=%0d", rsp_id, a, b, rsp_prod);
    next_cycle;
    #1;
    check_val("single_idle", 32'(busy), 0);
  endtask

  int ta   [4] = '{10, 30, 100, 255};
  int tb   [4] = '{20, 3, 100, 2};
  int texp [4] = '{200, 90, 10000, 510};

  initial begin
    int cyc;
    int n_acc;
    int n_rsp;
    int last_acc;
    int launched;
    int done_cnt;
    int got_g;
    int pa [4];
    int pb [4];
    int q_id [$];
    int q_prod [$];

    // Reset state, with all requests valid to show req_ready is held low.
    rst       = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_ready", 32'(req_ready), 0);
    check_val("reset_rsp_valid", 32'(rsp_valid), 0);
    check_val("reset_busy", 32'(busy), 0);
    check_val("reset_prod", 32'(rsp_prod), 0);
    check_val("reset_id", 32'(rsp_id), 0);
    req_valid = '0;
    next_cycle;
    rst = 1'b0;
    next_cycle;

    // Single requests and corner operands; the last grant (3) wraps ptr to 0.
    run_single(2, 12, 13, 156);
    run_single(1, 255, 255, 65025);
    run_single(0, 0, 200, 0);
    run_single(3, 1, 255, 255);

    // All requesters valid: grants rotate 0,1,2,3,0,... one every LAT cycles.
    for (int i = 0; i < NREQ; i++) set_ops(i, ta[i], tb[i]);
    rsp_ready = 1'b1;
    n_acc = 0;
    n_rsp = 0;
    last_acc = -100;
    for (int c = 0; c < 30; c++) begin
      req_valid = (c < 12) ? 4'hF : 4'h0;
      #1;
      check_val("rot_onehot", 32'($countones(req_ready) <= 1), 1);
      if (req_ready != '0) begin
        check_val("rot_grant", 32'(req_ready), 1 << (n_acc % 4));
        if (n_acc > 0) check_val("rot_spacing", c - last_acc, LAT);
        last_acc = c;
        n_acc++;
      end
      if (rsp_valid && rsp_ready) begin
        check_val("rot_id", 32'(rsp_id), n_rsp % 4);
        check_val("rot_prod", 32'(rsp_prod), texp[n_rsp % 4]);
        $display("txn rotate id=%0d prod=%0d", rsp_id, rsp_prod);
        n_rsp++;
      end
      next_cycle;
    end
    check_val("rot_accepts", n_acc, (12 + LAT - 1) / LAT);
    check_val("rot_responses", n_rsp, n_acc);

    // Backpressure: hold the response of requester 2 for 5 cycles.
    rsp_ready = 1'b0;
    req_valid = 4'b1100;
    #1;
    check_val("bp_grant", 32'(req_ready), 32'h4);
    next_cycle;
    req_valid = 4'b1000;
    wait_rsp(cyc);
    for (int k = 0; k < 5; k++) begin
      check_val("bp_hold_valid", 32'(rsp_valid), 1);
      check_val("bp_hold_prod", 32'(rsp_prod), 10000);
      check_val("bp_hold_id", 32'(rsp_id), 2);
      check_val("bp_hold_noready", 32'(req_ready), 0);
      next_cycle;
      #1;
    end
    rsp_ready = 1'b1;
    #1;
    check_val("bp_release_valid", 32'(rsp_valid), 1);
    check_val("bp_release_grant", 32'(req_ready), 32'h8);
    $display("txn backpressure id=%0d prod=%0d", rsp_id, rsp_prod);
    next_cycle;
    req_valid = '0;
    wait_rsp(cyc);
    check_val("bp_next_id", 32'(rsp_id), 3);
    check_val("bp_next_prod", 32'(rsp_prod), 510);
    $display("txn backpressure id=%0d prod=%0d", rsp_id, rsp_prod);
    next_cycle;

    // Reset while requester 1 is in CALC; its response must be discarded.
    set_ops(1, 3, 5);
    req_valid = 4'b0010;
    #1;
    check_val("rst_pre_grant", 32'(req_ready), 32'h2);
    next_cycle;
    req_valid = '0;
    #1;
    check_val("rst_pre_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check_val("rst_mid_busy", 32'(busy), 0);
    check_val("rst_mid_valid", 32'(rsp_valid), 0);
    check_val("rst_mid_prod", 32'(rsp_prod), 0);
    check_val("rst_mid_id", 32'(rsp_id), 0);
    check_val("rst_mid_ready", 32'(req_ready), 0);
    next_cycle;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val("rst_discard", 32'(rsp_valid), 0);
      next_cycle;
    end
    // ptr restarted at 0, so requester 1 beats requester 3.
    req_valid = 4'b1010;
    #1;
    check_val("rst_after_grant", 32'(req_ready), 32'h2);
    next_cycle;
    req_valid = '0;
    wait_rsp(cyc);
    check_val("rst_after_prod", 32'(rsp_prod), 15);
    check_val("rst_after_id", 32'(rsp_id), 1);
    $display("txn after_reset id=%0d prod=%0d", rsp_id, rsp_prod);
    next_cycle;

    // Randomized traffic against a*b with in-order response scoreboard.
    launched = 0;
    done_cnt = 0;
    req_valid = '0;
    for (int c = 0; c < 6000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && launched < 150 && $urandom_range(0, 2) == 0) begin
          pa[i] = int'($urandom_range(0, 255));
          pb[i] = int'($urandom_range(0, 255));
          set_ops(i, pa[i], pb[i]);
          req_valid[i] = 1'b1;
          launched++;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      check_val("rnd_onehot", 32'($countones(req_ready) <= 1), 1);
      check_val("rnd_ready_valid", 32'(req_ready & ~req_valid), 0);
      got_g = -1;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          got_g = i;
          q_id.push_back(i);
          q_prod.push_back(pa[i] * pb[i]);
        end
      end
      if (rsp_valid && rsp_ready) begin
        check_val("rnd_rsp_expected", 32'(q_id.size() != 0), 1);
        if (q_id.size() != 0) begin
          check_val("rnd_id", 32'(rsp_id), q_id.pop_front());
          check_val("rnd_prod", 32'(rsp_prod), q_prod.pop_front());
          $display("txn random id=%0d prod=%0d", rsp_id, rsp_prod);
          done_cnt++;
        end
      end
      next_cycle;
      if (got_g >= 0) req_valid[got_g] = 1'b0;
      if (launched >= 150 && req_valid == '0 && q_id.size() == 0 && !busy) break;
    end
    check_val("rnd_drained", q_id.size(), 0);
    check_val("rnd_count", done_cnt, 150);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
